// File: rtl/valurap_stepper_pkg.sv
// Shared definitions for the valurap stepper blocks: decoder FSM encoding,
// default synchronizer depth / period width, and the position width.
package valurap_stepper_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int PERIOD_W_DEF    = 32;
  localparam int POS_W           = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } step_state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous inputs.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/step_decoder.sv
// Step/direction decoder: tracks a 64-bit position from external step pulses,
// measures the step period and flags too-fast steps and direction-setup violations.
module step_decoder
  import valurap_stepper_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int PERIOD_W    = PERIOD_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    set_x,
  input  logic signed [POS_W-1:0] x_val,
  input  logic [PERIOD_W-1:0]     min_period,
  input  logic [7:0]              dir_setup,
  input  logic                    clear_err,
  output logic signed [POS_W-1:0] x,
  output logic [PERIOD_W-1:0]     period,
  output logic                    period_valid,
  output logic                    step_seen,
  output logic                    err_too_fast,
  output logic                    err_dir_setup
);

  logic                   w_s;
  logic                   w_d;
  logic                   r_s_prev;
  logic                   r_d_prev;
  logic                   r_arm;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [PERIOD_W-1:0]    r_cnt;
  logic [7:0]             r_dcnt;
  step_state_t            r_state;
  step_state_t            w_state_nxt;
  logic                   w_step;
  logic                   w_cnt_max;
  logic [PERIOD_W-1:0]    w_cnt_inc;
  logic                   w_d_changed;
  logic [7:0]             w_dcnt_eff;
  logic                   w_err_fast;
  logic                   w_err_dir;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_step (
    .clk   (clk),
    .reset (reset),
    .i_d   (step_in),
    .o_q   (w_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_dir (
    .clk   (clk),
    .reset (reset),
    .i_d   (dir_in),
    .o_q   (w_d)
  );

  // r_fill marks when s carries a real sample rather than the reset-cleared
  // chain, so a step_in held high through reset release never arms.
  assign w_step      = w_s & ~r_s_prev & r_arm;
  assign w_cnt_max   = &r_cnt;
  assign w_cnt_inc   = r_cnt + {{(PERIOD_W-1){1'b0}}, 1'b1};
  assign w_d_changed = (w_d != r_d_prev);
  assign w_dcnt_eff  = w_d_changed ? 8'd0 : r_dcnt;
  assign w_err_fast  = w_step && !set_x && (r_state == ST_RUN) && (w_cnt_inc < min_period);
  assign w_err_dir   = w_step && (w_dcnt_eff < dir_setup);

  always_comb begin
    w_state_nxt = r_state;
    if (set_x) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_step) w_state_nxt = ST_RUN;
        ST_RUN:  if (!w_step && w_cnt_max) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s_prev      <= 1'b0;
      r_d_prev      <= 1'b0;
      r_arm         <= 1'b0;
      r_fill        <= '0;
      r_cnt         <= '0;
      r_dcnt        <= '0;
      x             <= '0;
      period        <= '0;
      period_valid  <= 1'b0;
      step_seen     <= 1'b0;
      err_too_fast  <= 1'b0;
      err_dir_setup <= 1'b0;
    end else begin
      r_s_prev  <= w_s;
      r_d_prev  <= w_d;
      r_fill    <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      step_seen <= w_step;
      if (r_fill[SYNC_STAGES-1] && !w_s) r_arm <= 1'b1;

      r_dcnt <= (&w_dcnt_eff) ? w_dcnt_eff : w_dcnt_eff + 8'd1;

      if (set_x) begin
        x <= x_val;
      end else if (w_step) begin
        x <= w_d ? x + 64'sd1 : x - 64'sd1;
      end

      // Period measurement: a set_x step is swallowed and never measured.
      if (set_x) begin
        r_cnt        <= '0;
        period_valid <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (w_step) r_cnt <= '0;
      end else if (w_step) begin
        period       <= w_cnt_inc;
        period_valid <= 1'b1;
        r_cnt        <= '0;
      end else if (w_cnt_max) begin
        period_valid <= 1'b0;
      end else begin
        r_cnt <= w_cnt_inc;
      end

      err_too_fast  <= w_err_fast | (err_too_fast & ~clear_err);
      err_dir_setup <= w_err_dir | (err_dir_setup & ~clear_err);
    end
  end

endmodule
